// File: rtl/or_accum_16.sv
// Frame-based OR reduction over a valid/ready word stream, folding through or_16.
// Optional population-count output enabled by defining OR_ACCUM_POPCNT_EN.

module or_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a | b;
endmodule

module or_accum_16 #(
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [7:0]  out_count
`ifdef OR_ACCUM_POPCNT_EN
  ,
  output logic [4:0]  out_ones
`endif
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        accept;
  logic        closing;

  or_16 u_or (
    .a (acc),
    .b (in_data),
    .y (acc_next)
  );

  // cnt is 0 in IDLE, so this one compare also covers MAX_WORDS==1 there;
  // in_last on the final word just coincides with the same close.
  assign cnt_inc = cnt + 8'd1;
  assign accept  = in_valid && in_ready_q;
  assign closing = in_last || (cnt_inc == MAX_W8);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? acc : '0;
  assign out_count = out_valid_q ? cnt : '0;

`ifdef OR_ACCUM_POPCNT_EN
  logic [4:0] ones_q;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  assign out_ones = ones_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OR_ACCUM_POPCNT_EN
      ones_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            if (closing) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
`ifdef OR_ACCUM_POPCNT_EN
              ones_q      <= popcnt16(acc_next);
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef OR_ACCUM_POPCNT_EN
            ones_q      <= '0;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
`ifdef OR_ACCUM_POPCNT_EN
          ones_q      <= '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or_accum_16.sv
// Directed table vectors plus hand sequences and random frames for or_accum_16.
module tb_or_accum_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;
`ifdef OR_ACCUM_POPCNT_EN
  logic [4:0]  out_ones;
`endif

  int errors = 0;
  int checks = 0;

  or_accum_16 #(.MAX_WORDS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef OR_ACCUM_POPCNT_EN
    ,
    .out_ones  (out_ones)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [7:0]  exp_count;
    logic [4:0]  exp_ones;
    logic        pop;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic chk_ones(input string name, input logic [4:0] exp);
`ifdef OR_ACCUM_POPCNT_EN
    chk(name, 32'(out_ones), 32'(exp));
`else
    if (exp > 5'd16) $display("unexpected ones value %0d for %s", exp, name);
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
    chk({tag, ".out_count"}, 32'(out_count), 32'd0);
    chk_ones({tag, ".out_ones"}, 5'd0);
  endtask

  task automatic chk_done(input string tag, input logic [15:0] d, input logic [7:0] c,
                          input logic [4:0] o);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    chk({tag, ".out_count"}, 32'(out_count), 32'(c));
    chk_ones({tag, ".out_ones"}, o);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] model;
    int unsigned len;
    int unsigned budget;
    logic        lst;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk_idle("reset_async");
    step(); step();
    rst = 1'b0;
    step();
    chk_idle("after_reset");

    // Frame A: 0001, 0002, 8000(last)
    vt[0] = '{16'h0001, 1'b0, 1'b0, 16'h0000, 8'd0, 5'd0, 1'b0};
    vt[1] = '{16'h0002, 1'b0, 1'b0, 16'h0000, 8'd0, 5'd0, 1'b0};
    vt[2] = '{16'h8000, 1'b1, 1'b1, 16'h8003, 8'd3, 5'd3, 1'b1};
    // Frame B: 1<<i for i=0..7, auto-close on the 8th word
    for (int i = 0; i < 8; i++)
      vt[3 + i] = '{16'(1 << i), 1'b0, (i == 7), (i == 7) ? 16'h00FF : 16'h0000,
                    (i == 7) ? 8'd8 : 8'd0, (i == 7) ? 5'd8 : 5'd0, (i == 7)};
    // Frame C: in_last coincides with the 8th word, count must still be 8
    for (int i = 0; i < 8; i++)
      vt[11 + i] = '{16'(16'h0100 << i), (i == 7), (i == 7), (i == 7) ? 16'hFF00 : 16'h0000,
                     (i == 7) ? 8'd8 : 8'd0, (i == 7) ? 5'd8 : 5'd0, (i == 7)};
    // Frame D: single all-zero word
    vt[19] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 8'd1, 5'd0, 1'b1};

    for (int k = 0; k < 20; k++) begin
      chk($sformatf("vec%0d.in_ready_pre", k), 32'(in_ready), 32'd1);
      send(vt[k].data, vt[k].last);
      chk($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'(vt[k].exp_valid));
      chk($sformatf("vec%0d.in_ready", k),  32'(in_ready),  32'(!vt[k].exp_valid));
      chk($sformatf("vec%0d.out_data", k),  32'(out_data),  32'(vt[k].exp_data));
      chk($sformatf("vec%0d.out_count", k), 32'(out_count), 32'(vt[k].exp_count));
      chk_ones($sformatf("vec%0d.out_ones", k), vt[k].exp_ones);
      if (vt[k].pop) begin
        pop();
        chk_idle($sformatf("vec%0d.popped", k));
      end
    end

    // in_valid held while DONE must not be accepted
    for (int i = 0; i < 8; i++) send(16'(1 << i), 1'b0);
    in_valid = 1'b1; in_data = 16'hAAAA; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_done($sformatf("done_block%0d", i), 16'h00FF, 8'd8, 5'd8);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    pop();
    chk_idle("done_block_pop");

    // Backpressure: result held stable for 5 cycles
    send(16'h1234, 1'b0);
    send(16'h0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_done($sformatf("bp%0d", i), 16'h1235, 8'd2, 5'd6);
      step();
    end
    pop();
    chk_idle("bp_release");
    send(16'hFFFF, 1'b1);
    chk_done("full_word", 16'hFFFF, 8'd1, 5'd16);
    pop();

    // out_ready held high: exactly one blocked cycle between frames
    out_ready = 1'b1;
    send(16'h0010, 1'b1);
    chk_done("gap_done", 16'h0010, 8'd1, 5'd1);
    step();
    chk_idle("gap_idle");
    send(16'h0020, 1'b1);
    chk_done("gap_next", 16'h0020, 8'd1, 5'd1);
    out_ready = 1'b0;
    pop();

    // Asynchronous reset mid-frame discards the partial accumulation
    send(16'h00F0, 1'b0);
    send(16'h0F00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    step();
    rst = 1'b0;
    step();
    send(16'h0003, 1'b1);
    chk_done("post_rst", 16'h0003, 8'd1, 5'd2);
    pop();

    // Random frames against a software OR model
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 8);
      model = '0;
      for (int unsigned i = 0; i < len; i++) begin
        w = 16'($urandom);
        model = model | w;
        lst = (i == len - 1) ? ((len == 8) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        if (in_ready !== 1'b1) chk($sformatf("rnd%0d.in_ready", f), 32'(in_ready), 32'd1);
        send(w, lst);
      end
      chk($sformatf("rnd%0d.out_valid", f), 32'(out_valid), 32'd1);
      chk($sformatf("rnd%0d.out_data", f),  32'(out_data),  32'(model));
      chk($sformatf("rnd%0d.out_count", f), 32'(out_count), 32'(len));
      budget = 0;
      do begin
        out_ready = (budget >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        lst = out_ready;
        step();
        budget++;
        if (!lst && out_data !== model)
          chk($sformatf("rnd%0d.hold", f), 32'(out_data), 32'(model));
      end while (!lst && budget < 20);
      out_ready = 1'b0;
      chk($sformatf("rnd%0d.drained", f), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
